// File: rtl/p256_reducer_arbiter_if.sv
// Bundles the requester, response and reducer handshakes of the shared P-256 reducer.
// The slave side is the arbiter; the master side drives the requests and models the reducer.
interface p256_reducer_arbiter_if #(
    parameter int WIDTH = 256
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a_high;
    logic [WIDTH-1:0] req0_a_low;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a_high;
    logic [WIDTH-1:0] req1_a_low;
    logic             resp_valid;
    logic             resp_ready;
    logic             resp_id;
    logic             resp_err;
    logic [WIDTH-1:0] resp_data;
    logic             red_ena;
    logic [WIDTH-1:0] red_a_high;
    logic [WIDTH-1:0] red_a_low;
    logic             red_rdy;
    logic [WIDTH-1:0] red_out;
    logic             busy;

    modport slave (
        input  req0_valid, req0_a_high, req0_a_low,
        input  req1_valid, req1_a_high, req1_a_low,
        input  resp_ready, red_rdy, red_out,
        output req0_ready, req1_ready,
        output resp_valid, resp_id, resp_err, resp_data,
        output red_ena, red_a_high, red_a_low, busy
    );

    modport master (
        output req0_valid, req0_a_high, req0_a_low,
        output req1_valid, req1_a_high, req1_a_low,
        output resp_ready, red_rdy, red_out,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_id, resp_err, resp_data,
        input  red_ena, red_a_high, red_a_low, busy
    );
endinterface

// File: rtl/p256_reducer_arbiter.sv
// Round-robin share of one P-256 reducer between two requesters, with a watchdog
// that turns a reducer which never answers into an error response.
module p256_reducer_arbiter #(
    parameter int WIDTH          = 256,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TO_W           = 7
) (
    input  logic                    clk,
    input  logic                    rst_n,
    p256_reducer_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t           state_r;
    state_t           state_s;
    logic             last_grant_r;
    logic [TO_W-1:0]  wd_cnt_r;
    logic [WIDTH-1:0] red_a_high_r;
    logic [WIDTH-1:0] red_a_low_r;
    logic             resp_id_r;
    logic             resp_err_r;
    logic [WIDTH-1:0] resp_data_r;

    logic             any_valid_s;
    logic             grant_s;
    logic             accept_s;
    logic             timeout_s;
    logic [WIDTH-1:0] sel_high_s;
    logic [WIDTH-1:0] sel_low_s;

    // Grant selection: a lone requester wins, contention goes to the one not served last.
    always_comb begin
        any_valid_s = bus.req0_valid | bus.req1_valid;
        grant_s     = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_s = ~last_grant_r;
        end else if (bus.req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
        accept_s  = (state_r == IDLE) && any_valid_s;
        timeout_s = (wd_cnt_r == TO_LAST);
        if (grant_s) begin
            sel_high_s = bus.req1_a_high;
            sel_low_s  = bus.req1_a_low;
        end else begin
            sel_high_s = bus.req0_a_high;
            sel_low_s  = bus.req0_a_low;
        end
    end

    // Next-state decode; red_rdy takes precedence over a coincident timeout.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_valid_s) state_s = RUN;
                else             state_s = IDLE;
            end
            RUN: begin
                if (bus.red_rdy || timeout_s) state_s = RESP;
                else                          state_s = RUN;
            end
            RESP: begin
                if (bus.resp_ready) state_s = IDLE;
                else                state_s = RESP;
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand latch, grant history, watchdog and response capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_r <= 1'b1;
            wd_cnt_r     <= {TO_W{1'b0}};
            red_a_high_r <= {WIDTH{1'b0}};
            red_a_low_r  <= {WIDTH{1'b0}};
            resp_id_r    <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_data_r  <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        red_a_high_r <= sel_high_s;
                        red_a_low_r  <= sel_low_s;
                        resp_id_r    <= grant_s;
                        last_grant_r <= grant_s;
                        wd_cnt_r     <= {TO_W{1'b0}};
                    end
                end
                RUN: begin
                    wd_cnt_r <= wd_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
                    if (bus.red_rdy) begin
                        resp_data_r <= bus.red_out;
                        resp_err_r  <= 1'b0;
                    end else if (timeout_s) begin
                        resp_data_r <= {WIDTH{1'b0}};
                        resp_err_r  <= 1'b1;
                    end
                end
                RESP: begin
                    wd_cnt_r <= wd_cnt_r;
                end
                default: begin
                    wd_cnt_r <= {TO_W{1'b0}};
                end
            endcase
        end
    end

    // Ready is combinational so the accept lands in the same IDLE cycle as the grant.
    assign bus.req0_ready = (state_r == IDLE) && any_valid_s && (grant_s == 1'b0);
    assign bus.req1_ready = (state_r == IDLE) && any_valid_s && (grant_s == 1'b1);
    assign bus.red_ena    = (state_r == RUN);
    assign bus.red_a_high = red_a_high_r;
    assign bus.red_a_low  = red_a_low_r;
    assign bus.resp_valid = (state_r == RESP);
    assign bus.resp_id    = resp_id_r;
    assign bus.resp_err   = resp_err_r;
    assign bus.resp_data  = resp_data_r;
    assign bus.busy       = (state_r != IDLE);

endmodule

// File: tb/tb_p256_reducer_arbiter.sv
// Directed-vector bench for the shared P-256 reducer arbiter; the bench plays both
// requesters, the response consumer and the reducer.
module tb_p256_reducer_arbiter;

    localparam int W = 256;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    p256_reducer_arbiter_if #(.WIDTH(W)) bus ();

    p256_reducer_arbiter #(.WIDTH(W), .TIMEOUT_CYCLES(64), .TO_W(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    localparam logic [W-1:0] OP0_HI = 256'h1111_2222_3333_4444_5555_6666_7777_8888_9999_aaaa_bbbb_cccc_dddd_eeee_ffff_0000;
    localparam logic [W-1:0] OP0_LO = 256'h0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_00a0;
    localparam logic [W-1:0] OP1_HI = 256'hfedc_ba98_7654_3210_fedc_ba98_7654_3210_fedc_ba98_7654_3210_fedc_ba98_7654_3210;
    localparam logic [W-1:0] OP1_LO = 256'h0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_00b1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0_valid  = 1'b0;
        bus.req1_valid  = 1'b0;
        bus.req0_a_high = '0;
        bus.req0_a_low  = '0;
        bus.req1_a_high = '0;
        bus.req1_a_low  = '0;
        bus.resp_ready  = 1'b0;
        bus.red_rdy     = 1'b0;
        bus.red_out     = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        settle();
        n_cmp++; if (bus.red_ena !== 1'b0) begin n_fail++; $display("FAIL reset_red_ena: got %b want 0", bus.red_ena); end
        n_cmp++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", bus.resp_valid); end
        n_cmp++; if ({bus.resp_id, bus.resp_err, bus.busy} !== 3'b000) begin n_fail++; $display("FAIL reset_id_err_busy: got %b want 000", {bus.resp_id, bus.resp_err, bus.busy}); end
        n_cmp++; if (bus.resp_data !== 256'h0) begin n_fail++; $display("FAIL reset_resp_data: got %h want 0", bus.resp_data); end
        n_cmp++; if ({bus.red_a_high, bus.red_a_low} !== 512'h0) begin n_fail++; $display("FAIL reset_red_a: got %h want 0", bus.red_a_low); end
        n_cmp++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_readies: got %b want 00", {bus.req0_ready, bus.req1_ready}); end
    endtask

    task automatic test_single();
        apply_reset();
        bus.req0_valid  = 1'b1;
        bus.req0_a_high = 256'h0;
        bus.req0_a_low  = 256'h5;
        settle();
        n_cmp++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin n_fail++; $display("FAIL single_ready: got %b want 10", {bus.req0_ready, bus.req1_ready}); end
        tick();
        bus.req0_valid = 1'b0;
        bus.req0_a_low = 256'h9;
        for (int i = 1; i <= 4; i++) begin
            n_cmp++; if (bus.red_ena !== 1'b1) begin n_fail++; $display("FAIL single_red_ena cycle %0d: got %b want 1", i, bus.red_ena); end
            n_cmp++; if (bus.red_a_low !== 256'h5) begin n_fail++; $display("FAIL single_red_a_low cycle %0d: got %h want 5", i, bus.red_a_low); end
            if (i == 4) begin
                bus.red_rdy = 1'b1;
                bus.red_out = 256'h5;
            end
            tick();
        end
        bus.red_rdy = 1'b0;
        bus.red_out = 256'h0;
        n_cmp++; if ({bus.resp_valid, bus.red_ena, bus.busy} !== 3'b101) begin n_fail++; $display("FAIL single_resp_flags: got %b want 101", {bus.resp_valid, bus.red_ena, bus.busy}); end
        n_cmp++; if ({bus.resp_id, bus.resp_err} !== 2'b00) begin n_fail++; $display("FAIL single_id_err: got %b want 00", {bus.resp_id, bus.resp_err}); end
        n_cmp++; if (bus.resp_data !== 256'h5) begin n_fail++; $display("FAIL single_data: got %h want 5", bus.resp_data); end
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        n_cmp++; if ({bus.resp_valid, bus.busy} !== 2'b00) begin n_fail++; $display("FAIL single_back_idle: got %b want 00", {bus.resp_valid, bus.busy}); end
    endtask

    task automatic test_alternate();
        logic g;
        apply_reset();
        bus.req0_valid  = 1'b1;
        bus.req1_valid  = 1'b1;
        bus.req0_a_high = OP0_HI;
        bus.req0_a_low  = OP0_LO;
        bus.req1_a_high = OP1_HI;
        bus.req1_a_low  = OP1_LO;
        bus.resp_ready  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            g = (k % 2 == 1);
            settle();
            n_cmp++; if ({bus.req1_ready, bus.req0_ready} !== {g, ~g}) begin n_fail++; $display("FAIL alt_grant txn %0d: got %b want %b", k, {bus.req1_ready, bus.req0_ready}, {g, ~g}); end
            tick();
            n_cmp++; if (bus.red_a_high !== (g ? OP1_HI : OP0_HI)) begin n_fail++; $display("FAIL alt_operand txn %0d: got %h", k, bus.red_a_high); end
            n_cmp++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin n_fail++; $display("FAIL alt_ready_in_run txn %0d: got %b want 00", k, {bus.req0_ready, bus.req1_ready}); end
            bus.red_rdy = 1'b1;
            bus.red_out = 256'(k + 16);
            tick();
            bus.red_rdy = 1'b0;
            n_cmp++; if ({bus.resp_valid, bus.resp_id} !== {1'b1, g}) begin n_fail++; $display("FAIL alt_resp txn %0d: got %b want %b", k, {bus.resp_valid, bus.resp_id}, {1'b1, g}); end
            n_cmp++; if (bus.resp_data !== 256'(k + 16)) begin n_fail++; $display("FAIL alt_data txn %0d: got %h want %h", k, bus.resp_data, k + 16); end
            n_cmp++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin n_fail++; $display("FAIL alt_ready_in_resp txn %0d: got %b want 00", k, {bus.req0_ready, bus.req1_ready}); end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_resp_hold();
        apply_reset();
        bus.req1_valid  = 1'b1;
        bus.req1_a_low  = OP1_LO;
        tick();
        bus.req1_valid  = 1'b0;
        bus.red_rdy     = 1'b1;
        bus.red_out     = 256'hcafe;
        tick();
        bus.red_out     = 256'hbad0;
        bus.req0_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            settle();
            n_cmp++; if ({bus.resp_valid, bus.resp_id, bus.resp_err, bus.busy} !== 4'b1101) begin n_fail++; $display("FAIL hold_flags cycle %0d: got %b want 1101", i, {bus.resp_valid, bus.resp_id, bus.resp_err, bus.busy}); end
            n_cmp++; if (bus.resp_data !== 256'hcafe) begin n_fail++; $display("FAIL hold_data cycle %0d: got %h want cafe", i, bus.resp_data); end
            n_cmp++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin n_fail++; $display("FAIL hold_readies cycle %0d: got %b want 00", i, {bus.req0_ready, bus.req1_ready}); end
            tick();
        end
        idle_inputs();
        bus.resp_ready = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic test_timeout();
        int cnt;
        apply_reset();
        bus.req0_valid = 1'b1;
        tick();
        bus.req0_valid = 1'b0;
        cnt = 0;
        while (bus.red_ena === 1'b1 && cnt < 200) begin
            cnt++;
            tick();
        end
        n_cmp++; if (cnt !== 64) begin n_fail++; $display("FAIL timeout_ena_cycles: got %0d want 64", cnt); end
        n_cmp++; if ({bus.resp_valid, bus.resp_err} !== 2'b11) begin n_fail++; $display("FAIL timeout_err: got %b want 11", {bus.resp_valid, bus.resp_err}); end
        n_cmp++; if (bus.resp_data !== 256'h0) begin n_fail++; $display("FAIL timeout_data: got %h want 0", bus.resp_data); end
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_rdy_at_limit();
        apply_reset();
        bus.req0_valid = 1'b1;
        tick();
        bus.req0_valid = 1'b0;
        repeat (63) tick();
        n_cmp++; if (bus.red_ena !== 1'b1) begin n_fail++; $display("FAIL limit_still_running: got %b want 1", bus.red_ena); end
        bus.red_rdy = 1'b1;
        bus.red_out = OP1_HI;
        tick();
        bus.red_rdy = 1'b0;
        n_cmp++; if ({bus.resp_valid, bus.resp_err} !== 2'b10) begin n_fail++; $display("FAIL limit_err: got %b want 10", {bus.resp_valid, bus.resp_err}); end
        n_cmp++; if (bus.resp_data !== OP1_HI) begin n_fail++; $display("FAIL limit_data: got %h want %h", bus.resp_data, OP1_HI); end
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        apply_reset();
        bus.req1_valid = 1'b1;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({bus.red_ena, bus.busy, bus.resp_valid} !== 3'b000) begin n_fail++; $display("FAIL async_reset: got %b want 000", {bus.red_ena, bus.busy, bus.resp_valid}); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req1_a_low = OP1_LO;
        settle();
        n_cmp++; if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin n_fail++; $display("FAIL post_reset_req1: got %b want 01", {bus.req0_ready, bus.req1_ready}); end
        tick();
        bus.req1_valid = 1'b0;
        n_cmp++; if (bus.red_a_low !== OP1_LO) begin n_fail++; $display("FAIL post_reset_operand: got %h want %h", bus.red_a_low, OP1_LO); end
        bus.red_rdy = 1'b1;
        bus.red_out = 256'h77;
        tick();
        bus.red_rdy = 1'b0;
        n_cmp++; if ({bus.resp_valid, bus.resp_id} !== 2'b11) begin n_fail++; $display("FAIL post_reset_resp: got %b want 11", {bus.resp_valid, bus.resp_id}); end
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        settle();
        n_cmp++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin n_fail++; $display("FAIL post_reset_contention: got %b want 10", {bus.req0_ready, bus.req1_ready}); end
        idle_inputs();
        tick();
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        idle_inputs();
        test_reset();
        test_single();
        test_alternate();
        test_resp_hold();
        test_timeout();
        test_rdy_at_limit();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
